// File: rtl/spart_pkg.sv
// Shared SPART definitions: receive FSM states, register addresses and
// status-bit positions. Used by both the receive and transmit halves.
package spart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } spart_state_e;

  localparam logic [1:0] SPART_ADDR_BUF  = 2'b00;
  localparam logic [1:0] SPART_ADDR_STAT = 2'b01;

  localparam int STAT_RDA = 0;
  localparam int STAT_FE  = 1;
  localparam int STAT_OV  = 2;
  localparam int STAT_PE  = 3;

endpackage

// File: rtl/spart_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; both flops reset
// to 1 so an idle (high) line is seen during and after reset.
module spart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: oversampled deserialiser with a one-byte buffer and status
// register. Define SPART_RX_PARITY_EN to add an even-parity bit after the data.
module spart_rx
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       brg_en,
  input  logic       rxd,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  output logic [7:0] rd_data,
  output logic       rda,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [3:0] TICK_MID = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] TICK_END = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);
  localparam int         ALIGN    = 8 - DATA_BITS;

  spart_state_e state_q, state_d;
  logic [3:0]   tick_q, tick_d;
  logic [3:0]   bit_q, bit_d;
  logic [7:0]   shreg_q, shreg_d;
  logic [7:0]   buf_q, buf_d;
  logic [7:0]   rd_data_q, rd_data_d;
  logic         rda_q, rda_d;
  logic         fe_q, fe_d;
  logic         ov_q, ov_d;
  logic         rxs;
  logic         stop_sample;
  logic         buf_rd;
  logic         stat_rd;
  logic         parity_err;
  logic [7:0]   status;

`ifdef SPART_RX_PARITY_EN
  logic par_q, par_d;
  logic pe_q, pe_d;
  logic pe_set;
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif

  spart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs)
  );

  // Data bits enter at the MSB and shift down, so after the last bit the
  // byte is LSB-first aligned once shifted by the unused width.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    stop_sample = 1'b0;
`ifdef SPART_RX_PARITY_EN
    par_d  = par_q;
    pe_set = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (brg_en) begin
          if (tick_q == TICK_MID) begin
            tick_d = '0;
            if (rxs) begin
              state_d = ST_IDLE;
            end else begin
              bit_d   = '0;
              state_d = ST_DATA;
`ifdef SPART_RX_PARITY_EN
              par_d = 1'b0;
`endif
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (brg_en) begin
          if (tick_q == TICK_END) begin
            tick_d  = '0;
            shreg_d = {rxs, shreg_q[7:1]};
`ifdef SPART_RX_PARITY_EN
            par_d = par_q ^ rxs;
`endif
            if (bit_q == BIT_LAST) begin
`ifdef SPART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
`ifdef SPART_RX_PARITY_EN
      ST_PARITY: begin
        if (brg_en) begin
          if (tick_q == TICK_END) begin
            tick_d  = '0;
            pe_set  = par_q ^ rxs;
            state_d = ST_STOP;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (brg_en) begin
          if (tick_q == TICK_END) begin
            tick_d      = '0;
            stop_sample = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign buf_rd  = iocs && iorw && (ioaddr == SPART_ADDR_BUF);
  assign stat_rd = iocs && iorw && (ioaddr == SPART_ADDR_STAT);

  always_comb begin
    status           = '0;
    status[STAT_RDA] = rda_q;
    status[STAT_FE]  = fe_q;
    status[STAT_OV]  = ov_q;
    status[STAT_PE]  = parity_err;
  end

  // A load coinciding with a buffer read wins over the read's rda clear,
  // and the read itself consumed the old byte, so no overrun is flagged.
  always_comb begin
    buf_d     = buf_q;
    rd_data_d = rd_data_q;
    rda_d     = rda_q;
    fe_d      = fe_q;
    ov_d      = ov_q;
`ifdef SPART_RX_PARITY_EN
    pe_d = pe_q;
`endif
    if (buf_rd) begin
      rd_data_d = buf_q;
      rda_d     = 1'b0;
    end
    if (stat_rd) begin
      rd_data_d = status;
      fe_d      = 1'b0;
      ov_d      = 1'b0;
`ifdef SPART_RX_PARITY_EN
      pe_d = 1'b0;
`endif
    end
`ifdef SPART_RX_PARITY_EN
    if (pe_set) pe_d = 1'b1;
`endif
    if (stop_sample) begin
      if (!rxs) fe_d = 1'b1;
      if (!rda_q || buf_rd) begin
        buf_d = shreg_q >> ALIGN;
        rda_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      buf_q     <= '0;
      rd_data_q <= '0;
      rda_q     <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
`ifdef SPART_RX_PARITY_EN
      par_q <= 1'b0;
      pe_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      buf_q     <= buf_d;
      rd_data_q <= rd_data_d;
      rda_q     <= rda_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
`ifdef SPART_RX_PARITY_EN
      par_q <= par_d;
      pe_q  <= pe_d;
`endif
    end
  end

  assign rd_data   = rd_data_q;
  assign rda       = rda_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;

endmodule

// File: doc/spart_rx.md
# spart_rx

Receive half of the SPART serial port. It consumes the 16x oversampling enable from the baud rate generator (`brg_spart`'s `brg_en`) and deserialises the asynchronous `rxd` line into a one-byte receive buffer. The CPU reads the buffer over the 2-bit `ioaddr` register interface. Together with the existing transmit path and BRG, it completes the SPART.

## Interface
Parameters:
- `OVERSAMPLE`, 16: `brg_en` ticks per bit; must be even and at least 4.
- `DATA_BITS`, 8: payload bits per frame; at most 8.

Ports:
- `clk`, input, 1: system clock; all state is updated on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-low.
- `brg_en`, input, 1: one-`clk`-wide oversample tick from the BRG.
- `rxd`, input, 1: serial line, asynchronous, idles high.
- `iocs`, input, 1: chip select.
- `iorw`, input, 1: 1 = read.
- `ioaddr`, input, 2: register select. 00 = receive buffer, 01 = status.
- `rd_data`, output, 8: read data, registered.
- `rda`, output, 1: receive data available.
- `frame_err`, output, 1: sticky; stop bit sampled low.
- `overrun`, output, 1: sticky; a frame completed while `rda` = 1.

## Operation
- `rxd` always passes through a 2-flop synchroniser; `rxs` is the synchronised value.
- FSM states: IDLE, START, DATA, (PARITY), STOP. A tick counter (4 bits) and a bit counter track position within the frame.
- **IDLE:** on `rxs` = 0, clear the tick counter and go to START.
- **START:** count `brg_en` ticks. At tick `OVERSAMPLE/2` (mid-bit):
  - `rxs` = 1 → false start, return to IDLE.
  - otherwise clear the tick counter and go to DATA.
- **DATA:** sample `rxs` every `OVERSAMPLE` ticks, LSB first, into the shift register. After `DATA_BITS` samples go to PARITY if it is compiled in, else STOP.
- **STOP:** sample at the next `OVERSAMPLE` ticks.
  - Sample 0 → set `frame_err`.
  - If `rda` = 0 (or a buffer read occurs in the same cycle): load the shift register into the buffer and set `rda`.
  - If `rda` = 1 and there is no read that cycle: set `overrun` and discard the new byte; the buffer keeps the old byte.
  - Return to IDLE in every case. A following start bit is accepted immediately.
- **Buffer read** (`iocs`, `iorw`, `ioaddr` = 00): `rd_data` = buffer and `rda` is cleared.
  - If a read and a load happen in the same cycle, the new byte loads, `rda` stays 1 and `overrun` is not set.
- **Status read** (`ioaddr` = 01): `rd_data` = {4'b0, parity_err, overrun, frame_err, rda}. The read then clears `overrun`, `frame_err` and `parity_err`, but not `rda`.
- Writes, and reads at addresses 10/11, are ignored by this block and leave `rd_data` unchanged.
- `brg_en` held low freezes the FSM in place.

## Timing
- Reset values:
  - outputs `rd_data` = 8'h00 and `rda`, `frame_err`, `overrun` = 0;
  - internally, the FSM is in IDLE, counters are 0, and both synchroniser flops are 1.
- Reset asserted mid-frame aborts the frame with no load and no flag.
- `rd_data` is valid 1 `clk` after the read cycle. Flag clears are also visible 1 `clk` later.
- `rda` rises 1 `clk` after the STOP-sample cycle.
- End-to-end latency, from the `rxd` falling edge to `rda`, is 2 sync clocks plus (`DATA_BITS`+1)·`OVERSAMPLE` + `OVERSAMPLE/2` ticks (+`OVERSAMPLE` with parity), plus 1 `clk`.
- Start-bit detection jitter is up to one `brg_en` period.

## Configuration
- Macro: `SPART_RX_PARITY_EN`.
- **Defined:**
  - the PARITY state samples one extra bit after the data bits;
  - even parity over data plus parity bit;
  - a mismatch sets sticky `parity_err`, which is status bit 3;
  - the byte is still loaded.
- **Undefined:** no PARITY state, and status bit 3 reads 0.

## Structure
- Shared package `spart_pkg` holds:
  - the FSM state enum;
  - the register address constants (`SPART_ADDR_BUF` = 2'b00, `SPART_ADDR_STAT` = 2'b01);
  - the status-bit index constants.
- The transmitter uses the same package.
- One sub-module: `spart_sync2`, the 2-flop synchroniser, with its reset value at 1.

## Test plan
Bench drives `brg_en` high one cycle in every four.
- **Basic receive:** send 8'hA5 (start, 1010_0101 LSB first, stop) → `rda` = 1 and buffer read returns 8'hA5. Next status read returns 8'h00.
- **Framing error:** send 8'h3C with stop bit = 0 → `frame_err` = 1, buffer = 8'h3C, status = 8'h03.
- **Overrun:** send 8'h11 then 8'h22 with no read → `overrun` = 1 and buffer read returns 8'h11.
- **Read coincident with load:** read asserted in the STOP-load cycle of 8'h22 → buffer = 8'h22, `rda` = 1, `overrun` = 0.
- **False start:** `rxd` low for 3 ticks, then high → FSM returns to IDLE and no flags are set. A following 8'h5A is received correctly.
- **Reset mid-frame:** `rst` = 0 after the 4th data bit → all outputs return to reset values. Afterwards 8'hFF is received correctly.
